// File: rtl/apb_uart_pkg.sv
`default_nettype none
// ============================================================================
// apb_uart_pkg : shared types and register map for the APB UART peripherals
// Rev 1.0
// ============================================================================
package apb_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   localparam logic [3:0] ADDR_STATUS = 4'h0;
   localparam logic [3:0] ADDR_RXDATA = 4'h4;
   localparam logic [3:0] ADDR_CTRL   = 4'h8;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_FE    = 2;
   localparam int ST_OE    = 3;

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// uart_rx_frame : rx synchroniser, oversampling tick generator and 8N1 FSM
// Rev 1.0
// ============================================================================
module uart_rx_frame
   import apb_uart_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       i_rx,
   input  logic       i_rx_en,
   output logic       o_byte_valid,
   output logic [7:0] o_byte_data,
   output logic       o_frame_err
);

   localparam int CNT = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int CW  = (CNT > 1) ? $clog2(CNT) : 1;
   localparam logic [CW-1:0] C_CNT_LAST = CW'(CNT - 1);
   localparam logic [3:0]    C_HALF     = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0]    C_LAST     = 4'(OVERSAMPLE - 1);

   logic          r_rx_meta;
   logic          r_rx_s;
   logic          r_rx_d;
   logic [CW-1:0] r_div;
   logic          w_tick;
   rx_state_e     r_state;
   logic [3:0]    r_tcnt;
   logic [2:0]    r_bcnt;
   logic [7:0]    r_shift;
   logic          w_stop_smp;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_d    <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
         r_rx_d    <= r_rx_s;
      end
   end

   // Free-running: tick phase is deliberately not re-aligned to the start edge.
   assign w_tick = (r_div == C_CNT_LAST);

   always_ff @(posedge PCLK) begin
      if (!PRESETn)    r_div <= '0;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + 1'b1;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state <= IDLE;
         r_tcnt  <= 4'd0;
         r_bcnt  <= 3'd0;
         r_shift <= 8'd0;
      end else if (!i_rx_en) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_rx_d && !r_rx_s) begin
                  r_state <= START;
                  r_tcnt  <= 4'd0;
               end
            end
            START: begin
               if (w_tick) begin
                  if (r_tcnt == C_HALF) begin
                     r_tcnt <= 4'd0;
                     r_bcnt <= 3'd0;
                     r_state <= r_rx_s ? IDLE : DATA;
                  end else begin
                     r_tcnt <= r_tcnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_tcnt == C_LAST) begin
                     r_shift[r_bcnt] <= r_rx_s;
                     r_tcnt          <= 4'd0;
                     if (r_bcnt == 3'd7) r_state <= STOP;
                     else                r_bcnt  <= r_bcnt + 3'd1;
                  end else begin
                     r_tcnt <= r_tcnt + 4'd1;
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  if (r_tcnt == C_LAST) begin
                     r_tcnt  <= 4'd0;
                     r_state <= IDLE;
                  end else begin
                     r_tcnt <= r_tcnt + 4'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Combinational so the FIFO takes the byte on the stop-sample edge itself.
   assign w_stop_smp   = (r_state == STOP) && w_tick && (r_tcnt == C_LAST);
   assign o_byte_valid = w_stop_smp && r_rx_s;
   assign o_frame_err  = w_stop_smp && !r_rx_s;
   assign o_byte_data  = r_shift;

endmodule
`default_nettype wire

// File: rtl/apb_uart_rx_periph.sv
`default_nettype none
// ============================================================================
// apb_uart_rx_periph : APB slave UART receiver with byte FIFO and status regs
// Rev 1.0
// ============================================================================
module apb_uart_rx_periph
   import apb_uart_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic [3:0]  PADDR,
   input  logic [31:0] PWDATA,
   input  logic        PWRITE,
   input  logic        PSEL,
   input  logic        PENABLE,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   input  logic        rx,
   output logic        rx_avail
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [NW-1:0] C_DEPTH = NW'(FIFO_DEPTH);

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [NW-1:0] r_count;
   logic          r_fe;
   logic          r_oe;
   logic          r_rx_en;
   logic          r_pready;
   logic          r_pop_ok;
   logic [31:0]   r_prdata;

   logic          w_byte_valid;
   logic [7:0]    w_byte_data;
   logic          w_frame_err;
   logic [3:0]    w_addr;
   logic          w_setup;
   logic          w_done;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_ovr;
   logic          w_wr_status;
   logic          w_wr_ctrl;
   logic [31:0]   w_rdata;
   logic          w_unused;

   uart_rx_frame #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_frame (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .i_rx         (rx),
      .i_rx_en      (r_rx_en),
      .o_byte_valid (w_byte_valid),
      .o_byte_data  (w_byte_data),
      .o_frame_err  (w_frame_err)
   );

   assign w_addr      = {PADDR[3:2], 2'b00};
   assign w_setup     = PSEL & PENABLE & ~r_pready;
   assign w_done      = PSEL & PENABLE & r_pready;
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == C_DEPTH);
   assign w_pop       = w_done & ~PWRITE & (w_addr == ADDR_RXDATA) & r_pop_ok;
   assign w_push      = w_byte_valid & (~w_full | w_pop);
   assign w_ovr       = w_byte_valid & w_full & ~w_pop;
   assign w_wr_status = w_done & PWRITE & (w_addr == ADDR_STATUS);
   assign w_wr_ctrl   = w_done & PWRITE & (w_addr == ADDR_CTRL);
   assign w_unused    = &{1'b0, PADDR[1:0], PWDATA[31:4], PWDATA[1]};

   always_comb begin
      w_rdata = 32'd0;
      case (w_addr)
         ADDR_STATUS: begin
            w_rdata[ST_EMPTY] = w_empty;
            w_rdata[ST_FULL]  = w_full;
            w_rdata[ST_FE]    = r_fe;
            w_rdata[ST_OE]    = r_oe;
         end
         ADDR_RXDATA: if (!w_empty) w_rdata[7:0] = r_mem[r_rptr];
         ADDR_CTRL:   w_rdata[0] = r_rx_en;
         default:     w_rdata = 32'd0;
      endcase
   end

   // Pop eligibility is latched at setup so a byte arriving mid-access is never
   // popped by a read that returned 0.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_pready <= 1'b0;
         r_prdata <= 32'd0;
         r_pop_ok <= 1'b0;
      end else begin
         r_pready <= w_setup;
         if (w_setup) begin
            r_prdata <= PWRITE ? 32'd0 : w_rdata;
            r_pop_ok <= ~PWRITE & (w_addr == ADDR_RXDATA) & ~w_empty;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (w_push) r_mem[r_wptr] <= w_byte_data;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // A new error event wins over a simultaneous write-1-to-clear.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_fe    <= 1'b0;
         r_oe    <= 1'b0;
         r_rx_en <= 1'b1;
      end else begin
         r_fe <= w_frame_err | (r_fe & ~(w_wr_status & PWDATA[ST_FE]));
         r_oe <= w_ovr       | (r_oe & ~(w_wr_status & PWDATA[ST_OE]));
         if (w_wr_ctrl) r_rx_en <= PWDATA[0];
      end
   end

   assign PRDATA   = r_prdata;
   assign PREADY   = r_pready;
   assign rx_avail = ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_rx_periph.sv
`default_nettype none
// ============================================================================
// tb_apb_uart_rx_periph : directed self-checking bench for apb_uart_rx_periph
// Rev 1.0
// ============================================================================
module tb_apb_uart_rx_periph;

   localparam int BIT = 160;

   logic        PCLK    = 1'b0;
   logic        PRESETn = 1'b0;
   logic [3:0]  PADDR   = 4'h0;
   logic [31:0] PWDATA  = 32'h0;
   logic        PWRITE  = 1'b0;
   logic        PSEL    = 1'b0;
   logic        PENABLE = 1'b0;
   logic        rx      = 1'b1;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        rx_avail;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int base         = 0;
   logic [31:0] d;
   int          w;

   apb_uart_rx_periph #(
      .CLK_HZ     (1_600_000),
      .BAUD       (10_000),
      .OVERSAMPLE (16),
      .FIFO_DEPTH (4)
   ) dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PWRITE   (PWRITE),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .rx       (rx),
      .rx_avail (rx_avail)
   );

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   // Edge n after reset release has cyc == base + n; ticks land on n % 10 == 9.
   task automatic do_reset();
      @(posedge PCLK); #1 PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      repeat (2) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      base = cyc + 1;
   endtask

   task automatic align();
      while (((cyc - base) % 10) != 0) begin
         @(posedge PCLK); #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop);
      rx = 1'b0;
      repeat (BIT) @(posedge PCLK);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (BIT) @(posedge PCLK);
         #1;
      end
      rx = stop;
      repeat (BIT) @(posedge PCLK);
      #1 rx = 1'b1;
   endtask

   task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int waits);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      waits = 0;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      @(negedge PCLK);
      while (PREADY !== 1'b1 && waits < 16) begin
         waits++;
         @(negedge PCLK);
      end
      tests_run++;
      if (PREADY !== 1'b1) begin
         $display("FAIL apb_timeout: PREADY=%b after %0d waits, required 1", PREADY, waits);
         tests_failed++;
      end
      rdata = PRDATA;
      @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      if (PREADY !== 1'b0) begin $display("FAIL reset_pready: got %b required 0", PREADY); tests_failed++; end
      tests_run++;
      if (rx_avail !== 1'b0) begin $display("FAIL reset_rx_avail: got %b required 0", rx_avail); tests_failed++; end
      tests_run++;
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h1) begin $display("FAIL reset_status: got %h required %h", d, 32'h1); tests_failed++; end
      tests_run++;
      apb_xfer(1'b0, 4'h8, 32'h0, d, w);
      if (d !== 32'h1) begin $display("FAIL reset_ctrl: got %h required %h", d, 32'h1); tests_failed++; end
      tests_run++;
   endtask

   task automatic test_single_byte();
      align();
      send_frame(8'hA5, 1'b1);
      if (rx_avail !== 1'b1) begin $display("FAIL single_rx_avail: got %b required 1", rx_avail); tests_failed++; end
      tests_run++;
      apb_xfer(1'b0, 4'h4, 32'h0, d, w);
      if (d !== 32'hA5) begin $display("FAIL single_rxdata: got %h required %h", d, 32'hA5); tests_failed++; end
      tests_run++;
      if (w !== 1) begin $display("FAIL single_rxdata_waits: got %0d required 1", w); tests_failed++; end
      tests_run++;
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h1) begin $display("FAIL single_status: got %h required %h", d, 32'h1); tests_failed++; end
      tests_run++;
      if (w !== 1) begin $display("FAIL single_status_waits: got %0d required 1", w); tests_failed++; end
      tests_run++;
      if (rx_avail !== 1'b0) begin $display("FAIL single_rx_avail_clr: got %b required 0", rx_avail); tests_failed++; end
      tests_run++;
   endtask

   task automatic test_overrun();
      align();
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'hA) begin $display("FAIL overrun_status: got %h required %h", d, 32'hA); tests_failed++; end
      tests_run++;
      for (int i = 1; i <= 4; i++) begin
         apb_xfer(1'b0, 4'h4, 32'h0, d, w);
         if (d !== 32'(i)) begin $display("FAIL overrun_rxdata%0d: got %h required %h", i, d, 32'(i)); tests_failed++; end
         tests_run++;
      end
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h9) begin $display("FAIL overrun_status_drained: got %h required %h", d, 32'h9); tests_failed++; end
      tests_run++;
      apb_xfer(1'b1, 4'h0, 32'h8, d, w);
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h1) begin $display("FAIL overrun_w1c: got %h required %h", d, 32'h1); tests_failed++; end
      tests_run++;
   endtask

   task automatic test_framing();
      align();
      send_frame(8'h3C, 1'b0);
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h5) begin $display("FAIL framing_status: got %h required %h", d, 32'h5); tests_failed++; end
      tests_run++;
      apb_xfer(1'b1, 4'h0, 32'h4, d, w);
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h1) begin $display("FAIL framing_w1c: got %h required %h", d, 32'h1); tests_failed++; end
      tests_run++;
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      repeat (40) @(posedge PCLK);
      #1 rx = 1'b1;
      repeat (2000) @(posedge PCLK);
      #1;
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h1) begin $display("FAIL glitch_status: got %h required %h", d, 32'h1); tests_failed++; end
      tests_run++;
   endtask

   task automatic test_rx_enable();
      apb_xfer(1'b1, 4'h8, 32'h0, d, w);
      apb_xfer(1'b0, 4'h8, 32'h0, d, w);
      if (d !== 32'h0) begin $display("FAIL rxen_ctrl_off: got %h required %h", d, 32'h0); tests_failed++; end
      tests_run++;
      align();
      send_frame(8'h77, 1'b1);
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h1) begin $display("FAIL rxen_disabled_status: got %h required %h", d, 32'h1); tests_failed++; end
      tests_run++;
      apb_xfer(1'b1, 4'h8, 32'h1, d, w);
      align();
      send_frame(8'h66, 1'b1);
      apb_xfer(1'b0, 4'h4, 32'h0, d, w);
      if (d !== 32'h66) begin $display("FAIL rxen_reenabled_rxdata: got %h required %h", d, 32'h66); tests_failed++; end
      tests_run++;
   endtask

   task automatic test_push_pop();
      logic [31:0] rd;
      int          rw;
      logic [7:0]  exp_q [4];
      exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
      align();
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h2) begin $display("FAIL pushpop_full: got %h required %h", d, 32'h2); tests_failed++; end
      tests_run++;
      // Stop-sample tick edge is 1519 cycles after an aligned start bit.
      align();
      fork
         send_frame(8'h55, 1'b1);
         begin
            repeat (1516) @(posedge PCLK);
            #1 apb_xfer(1'b0, 4'h4, 32'h0, rd, rw);
         end
      join
      if (rd !== 32'h11) begin $display("FAIL pushpop_head: got %h required %h", rd, 32'h11); tests_failed++; end
      tests_run++;
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h2) begin $display("FAIL pushpop_status: got %h required %h", d, 32'h2); tests_failed++; end
      tests_run++;
      for (int i = 0; i < 4; i++) begin
         apb_xfer(1'b0, 4'h4, 32'h0, d, w);
         if (d !== {24'h0, exp_q[i]}) begin $display("FAIL pushpop_drain%0d: got %h required %h", i, d, {24'h0, exp_q[i]}); tests_failed++; end
         tests_run++;
      end
      apb_xfer(1'b0, 4'h4, 32'h0, d, w);
      if (d !== 32'h0) begin $display("FAIL pushpop_empty_read: got %h required %h", d, 32'h0); tests_failed++; end
      tests_run++;
   endtask

   task automatic test_mid_frame_reset();
      align();
      rx = 1'b0;
      repeat (400) @(posedge PCLK);
      #1 PRESETn = 1'b0;
      repeat (2) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      base = cyc + 1;
      repeat (30) @(posedge PCLK);
      #1 rx = 1'b1;
      repeat (2000) @(posedge PCLK);
      #1;
      apb_xfer(1'b0, 4'h0, 32'h0, d, w);
      if (d !== 32'h1) begin $display("FAIL midreset_status: got %h required %h", d, 32'h1); tests_failed++; end
      tests_run++;
      align();
      send_frame(8'h5A, 1'b1);
      apb_xfer(1'b0, 4'h4, 32'h0, d, w);
      if (d !== 32'h5A) begin $display("FAIL midreset_new_frame: got %h required %h", d, 32'h5A); tests_failed++; end
      tests_run++;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_overrun();
      test_framing();
      test_glitch();
      test_rx_enable();
      test_push_pop();
      test_mid_frame_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
